// File: rtl/bram_line_adapter.sv
// bram_line_adapter
//   Turns one cache-line read/write request from the memory arbiter into
//   BEATS back-to-back single-word accesses on a native single-port BRAM
//   (ena/wea/addra/dina/douta). The BRAM returns read data one cycle after
//   the issue, so read beats are captured through a one-stage
//   capture-valid pipeline, and a DRAIN state collects the final word.
//   Completion is a one-cycle req_resp pulse, with the assembled line on
//   req_rdata.
//
//   All BRAM-side outputs are registered. bram_addra, bram_dina and
//   bram_wea are forced to zero whenever bram_ena is low.
//
//   Optional build macro BRAM_LINE_ADAPTER_CHECK_EN enables protocol
//   checks: both requests high in IDLE, a request dropped mid-transfer,
//   and X on req_addr, req_wdata or bram_douta when they are consumed.
//   Each one raises $error and sets the sticky err flag. Without the
//   macro, err reflects only bram_error. The macro does not change the
//   cycle behaviour.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting; samples req_write (priority) then req_read
//   WRITE | one BRAM write per cycle, beat 0..BEATS-1
//   READ  | one BRAM read issue per cycle, beat 0..BEATS-1
//   DRAIN | no issue; the last read word is captured this cycle
//   RESP  | req_resp pulse; line valid on req_rdata

module bram_line_adapter #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 32,
    parameter int BEATS         = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   req_addr,
    input  logic                          req_read,
    input  logic                          req_write,
    input  logic [DATA_WIDTH*BEATS-1:0]   req_wdata,
    output logic [DATA_WIDTH*BEATS-1:0]   req_rdata,
    output logic                          req_resp,
    output logic                          bram_ena,
    output logic                          bram_wea,
    output logic [ADDRESS_WIDTH-1:0]      bram_addra,
    output logic [DATA_WIDTH-1:0]         bram_dina,
    input  logic [DATA_WIDTH-1:0]         bram_douta,
    input  logic                          bram_error,
    output logic                          err
);

    localparam int LINE_W     = DATA_WIDTH * BEATS;
    localparam int BEAT_W     = $clog2(BEATS);
    localparam int WORD_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t                    state;
    logic [BEAT_W-1:0]         beat;
    logic [BEAT_W-1:0]         next_beat;
    logic                      cap_valid;
    logic [BEAT_W-1:0]         cap_idx;
    logic [ADDRESS_WIDTH-1:0]  base_q;
    logic [ADDRESS_WIDTH-1:0]  base_req;
    logic [31:0]               word_addr;
    logic [LINE_W-1:0]         wdata_q;
    logic [LINE_W-1:0]         line_q;
    logic                      chk_viol;

    // Byte address to line-aligned word address; the low beat bits are
    // cleared so base+beat can never carry out of the line.
    assign word_addr = req_addr >> WORD_SHIFT;
    assign base_req  = ADDRESS_WIDTH'(word_addr) & ~ADDRESS_WIDTH'(BEATS - 1);
    assign next_beat = beat + 1'b1;
    assign req_rdata = line_q;

`ifdef BRAM_LINE_ADAPTER_CHECK_EN
    logic chk_both;
    logic chk_drop;
    logic chk_addr_x;
    logic chk_wdata_x;
    logic chk_douta_x;

    // Protocol violation detection on the current cycle's inputs.
    always_comb begin
        chk_both    = 1'b0;
        chk_drop    = 1'b0;
        chk_addr_x  = 1'b0;
        chk_wdata_x = 1'b0;
        chk_douta_x = 1'b0;
        if (state == IDLE) begin
            chk_both    = req_read && req_write;
            chk_addr_x  = (req_read || req_write) && $isunknown(req_addr);
            chk_wdata_x = req_write && $isunknown(req_wdata);
        end
        if (state == WRITE) begin
            chk_drop = !req_write;
        end
        if ((state == READ) || (state == DRAIN)) begin
            chk_drop = !req_read;
        end
        if (cap_valid) begin
            chk_douta_x = $isunknown(bram_douta);
        end
    end

    assign chk_viol = chk_both | chk_drop | chk_addr_x | chk_wdata_x | chk_douta_x;

    // Report each violation once per offending cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (chk_both)    $error("bram_line_adapter: req_read and req_write both high in IDLE");
            if (chk_drop)    $error("bram_line_adapter: request dropped before req_resp");
            if (chk_addr_x)  $error("bram_line_adapter: X on req_addr at acceptance");
            if (chk_wdata_x) $error("bram_line_adapter: X on req_wdata at write acceptance");
            if (chk_douta_x) $error("bram_line_adapter: X on bram_douta in capture cycle");
        end
    end
`else
    assign chk_viol = 1'b0;
`endif

    // Sequencer: state, beat counter, registered BRAM/response outputs,
    // read capture pipeline and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat       <= '0;
            cap_valid  <= 1'b0;
            cap_idx    <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            line_q     <= '0;
            req_resp   <= 1'b0;
            bram_ena   <= 1'b0;
            bram_wea   <= 1'b0;
            bram_addra <= '0;
            bram_dina  <= '0;
            err        <= 1'b0;
        end else begin
            // Idle values; states below override for active beats.
            req_resp   <= 1'b0;
            bram_ena   <= 1'b0;
            bram_wea   <= 1'b0;
            bram_addra <= '0;
            bram_dina  <= '0;
            cap_valid  <= 1'b0;
            err        <= err | bram_error | chk_viol;

            // Data for the read issued last cycle is on douta now.
            if (cap_valid) begin
                line_q[cap_idx*DATA_WIDTH +: DATA_WIDTH] <= bram_douta;
            end

            case (state)
                IDLE: begin
                    if (req_write) begin
                        state      <= WRITE;
                        beat       <= '0;
                        base_q     <= base_req;
                        wdata_q    <= req_wdata;
                        bram_ena   <= 1'b1;
                        bram_wea   <= 1'b1;
                        bram_addra <= base_req;
                        bram_dina  <= req_wdata[DATA_WIDTH-1:0];
                    end else if (req_read) begin
                        state      <= READ;
                        beat       <= '0;
                        base_q     <= base_req;
                        bram_ena   <= 1'b1;
                        bram_addra <= base_req;
                    end
                end

                WRITE: begin
                    if (beat == LAST_BEAT) begin
                        state    <= RESP;
                        req_resp <= 1'b1;
                    end else begin
                        beat       <= next_beat;
                        bram_ena   <= 1'b1;
                        bram_wea   <= 1'b1;
                        bram_addra <= base_q + ADDRESS_WIDTH'(next_beat);
                        bram_dina  <= wdata_q[next_beat*DATA_WIDTH +: DATA_WIDTH];
                    end
                end

                READ: begin
                    cap_valid <= 1'b1;
                    cap_idx   <= beat;
                    if (beat == LAST_BEAT) begin
                        state <= DRAIN;
                    end else begin
                        beat       <= next_beat;
                        bram_ena   <= 1'b1;
                        bram_addra <= base_q + ADDRESS_WIDTH'(next_beat);
                    end
                end

                DRAIN: begin
                    state    <= RESP;
                    req_resp <= 1'b1;
                end

                RESP: begin
                    state <= IDLE;
                    beat  <= '0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
